pwm_modulator: RTL and testbench

- Consumes the 7-bit duty word produced by the sawtooth/duty generator stage.
- Converts it into a single glitch-free PWM output bit that drives the output pin/LED/audio stage.
- Duty is double-buffered and changes only at period boundaries.
- Disabling the block lets the current period finish cleanly before the output parks low.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_tick_gen.sv | 29 ++
 rtl/pwm_modulator.sv | 108 ++++++++++
 tb/tb_pwm_modulator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types, default sizing and the duty saturation helper for the PWM
// modulator.
package pwm_pkg;

  localparam int DEF_PRESCALE = 4;
  localparam int DEF_STEPS    = 100;
  localparam int DEF_DUTY_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clamp a requested duty to the number of steps in one period.
  function automatic int unsigned sat(input int unsigned d, input int unsigned steps);
    return (d >= steps) ? steps : d;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: emits one tick every PRESCALE cycles while run is high and
// restarts from zero whenever run drops.
module pwm_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_reg;

  always_ff @(posedge sysclk) begin
    if (!rst_n || !run) begin
      presc_reg <= '0;
    end else if (presc_reg == LAST) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  assign tick = run && (presc_reg == LAST);

endmodule

// File: rtl/pwm_modulator.sv
// PWM modulator: double-buffered duty, period-aligned start/stop and a
// registered, glitch-free output derived from next-state values.
module pwm_modulator
  import pwm_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int STEPS    = DEF_STEPS,
  parameter int DUTY_W   = DEF_DUTY_W
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_in,
  output logic              pwm_out,
  output logic              period_start,
  output logic              busy,
  output logic [DUTY_W-1:0] duty_active
);

  localparam logic [DUTY_W-1:0] LAST_STEP = DUTY_W'(STEPS - 1);

  state_t            state_reg, state_next;
  logic [DUTY_W-1:0] step_reg, step_next;
  logic [DUTY_W-1:0] duty_reg, duty_next;
  logic              pwm_reg, pwm_next;
  logic              ps_reg, ps_next;
  logic              busy_reg;
  logic              run, tick, wrap;
  logic [DUTY_W-1:0] duty_sat;

  assign run      = (state_reg != IDLE);
  assign wrap     = tick && (step_reg == LAST_STEP);
  assign duty_sat = DUTY_W'(sat(32'(duty_in), 32'(STEPS)));

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    duty_next  = duty_reg;
    ps_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        step_next = '0;
        if (enable) begin
          state_next = RUN;
          duty_next  = duty_sat;
          ps_next    = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (wrap) begin
          step_next = '0;
          if (enable) begin
            state_next = RUN;
            duty_next  = duty_sat;
            ps_next    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (tick) begin
            step_next = step_reg + DUTY_W'(1);
          end
          // Dropping enable mid-period only marks the period as the last one.
          state_next = enable ? RUN : DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
        step_next  = '0;
      end
    endcase
    // Compare against next-state values so the output lines up with period_start.
    pwm_next = (state_next != IDLE) && (step_next < duty_next);
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      duty_reg  <= '0;
      pwm_reg   <= 1'b0;
      ps_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      duty_reg  <= duty_next;
      pwm_reg   <= pwm_next;
      ps_reg    <= ps_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign pwm_out      = pwm_reg;
  assign period_start = ps_reg;
  assign busy         = busy_reg;
  assign duty_active  = duty_reg;

endmodule

// File: tb/tb_pwm_modulator.sv
// Self-checking bench: table vectors, directed corner sequences and random
// stimulus compared each cycle against a period-position reference model.
module tb_pwm_modulator;

  localparam int P      = 4;
  localparam int S      = 100;
  localparam int PERIOD = P * S;

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic [6:0] duty_in;
  logic       pwm_out, period_start, busy;
  logic [6:0] duty_active;

  logic       rst2_n, en2;
  logic [6:0] duty2;
  logic       pwm2, ps2, busy2;
  logic [6:0] da2;

  int checks = 0;
  int errors = 0;

  // Reference model: position inside the period plus the latched duty.
  bit m_active;
  int m_cyc;
  int m_duty;
  bit m_ps;

  always #5 clk = ~clk;

  pwm_modulator #(.PRESCALE(P), .STEPS(S), .DUTY_W(7)) dut (
    .sysclk(clk), .rst_n(rst_n), .enable(enable), .duty_in(duty_in),
    .pwm_out(pwm_out), .period_start(period_start), .busy(busy),
    .duty_active(duty_active)
  );

  pwm_modulator #(.PRESCALE(1), .STEPS(2), .DUTY_W(7)) dut2 (
    .sysclk(clk), .rst_n(rst2_n), .enable(en2), .duty_in(duty2),
    .pwm_out(pwm2), .period_start(ps2), .busy(busy2), .duty_active(da2)
  );

  typedef struct {
    int duty;
    int periods;
    int exp_high;
    int exp_duty;
  } vec_t;

  vec_t vecs[6];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  function automatic int sat_ref(input int d);
    return (d >= S) ? S : d;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_active = 0; m_cyc = 0; m_duty = 0; m_ps = 0;
    end else if (!m_active) begin
      m_ps = 0;
      if (enable) begin
        m_active = 1; m_cyc = 0; m_duty = sat_ref(int'(duty_in)); m_ps = 1;
      end
    end else if (m_cyc == PERIOD - 1) begin
      m_cyc = 0;
      m_ps  = 0;
      if (enable) begin
        m_duty = sat_ref(int'(duty_in)); m_ps = 1;
      end else begin
        m_active = 0;
      end
    end else begin
      m_cyc++;
      m_ps = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    cmp("model_pwm",   32'(pwm_out),      32'(m_active && ((m_cyc / P) < m_duty)));
    cmp("model_ps",    32'(period_start), 32'(m_ps));
    cmp("model_busy",  32'(busy),         32'(m_active));
    cmp("model_duty",  32'(duty_active),  32'(m_duty));
  endtask

  task automatic restart(input int d);
    rst_n = 1'b0; enable = 1'b0; duty_in = 7'(d);
    tick();
    rst_n = 1'b1; enable = 1'b1;
    tick();
  endtask

  initial begin
    int high;
    vecs[0] = '{25, 2, 100, 25};
    vecs[1] = '{0, 1, 0, 0};
    vecs[2] = '{127, 3, 400, 100};
    vecs[3] = '{100, 1, 400, 100};
    vecs[4] = '{99, 1, 396, 99};
    vecs[5] = '{1, 1, 4, 1};

    rst_n = 1'b0; enable = 1'b0; duty_in = '0;
    rst2_n = 1'b0; en2 = 1'b0; duty2 = '0;
    tick();
    cmp("reset_pwm", 32'(pwm_out), 0);
    cmp("reset_busy", 32'(busy), 0);
    cmp("reset_duty", 32'(duty_active), 0);
    rst_n = 1'b1;
    tick();
    cmp("idle_busy", 32'(busy), 0);

    for (int v = 0; v < 6; v++) begin
      restart(vecs[v].duty);
      for (int p = 0; p < vecs[v].periods; p++) begin
        high = 0;
        for (int c = 0; c < PERIOD; c++) begin
          if (c == 0) cmp("vec_period_start", 32'(period_start), 1);
          if (pwm_out) high++;
          tick();
        end
        cmp("vec_high_count", 32'(high), 32'(vecs[v].exp_high));
      end
      cmp("vec_duty_active", 32'(duty_active), 32'(vecs[v].exp_duty));
      $display("vec %0d duty_in=%0d periods=%0d last_high=%0d", v, vecs[v].duty, vecs[v].periods, high);
    end

    // Duty change mid-period applies only from the next period.
    restart(25);
    high = 0;
    for (int c = 0; c < PERIOD; c++) begin
      if (c == 50) duty_in = 7'd75;
      if (c == PERIOD - 1) cmp("chg_old_duty", 32'(duty_active), 25);
      if (pwm_out) high++;
      tick();
    end
    cmp("chg_first_high", 32'(high), 100);
    cmp("chg_ps", 32'(period_start), 1);
    cmp("chg_new_duty", 32'(duty_active), 75);
    high = 0;
    for (int c = 0; c < PERIOD; c++) begin
      if (pwm_out) high++;
      tick();
    end
    cmp("chg_second_high", 32'(high), 300);
    $display("duty change: second period high=%0d", high);

    // Disable mid-period: period completes, then idle.
    restart(50);
    for (int c = 0; c < PERIOD; c++) begin
      if (c == 200) enable = 1'b0;
      if (c == PERIOD - 1) cmp("drain_busy", 32'(busy), 1);
      tick();
    end
    cmp("drain_idle_busy", 32'(busy), 0);
    cmp("drain_idle_pwm", 32'(pwm_out), 0);
    cmp("drain_idle_ps", 32'(period_start), 0);
    $display("drain: busy=%0b pwm=%0b after period end", busy, pwm_out);

    // Re-enable during the drain: next period starts on time.
    restart(50);
    for (int c = 0; c < PERIOD; c++) begin
      if (c == 200) enable = 1'b0;
      if (c == 300) enable = 1'b1;
      tick();
    end
    cmp("reen_ps", 32'(period_start), 1);
    cmp("reen_busy", 32'(busy), 1);
    cmp("reen_pwm", 32'(pwm_out), 1);
    $display("re-enable: period_start=%0b busy=%0b", period_start, busy);

    // One-cycle reset mid-period.
    restart(50);
    for (int c = 0; c < 30; c++) tick();
    rst_n = 1'b0;
    tick();
    cmp("rst_mid_pwm", 32'(pwm_out), 0);
    cmp("rst_mid_busy", 32'(busy), 0);
    cmp("rst_mid_duty", 32'(duty_active), 0);
    rst_n = 1'b1;
    tick();
    cmp("rst_mid_ps", 32'(period_start), 1);
    cmp("rst_mid_newduty", 32'(duty_active), 50);
    $display("mid-period reset: restart ps=%0b duty_active=%0d", period_start, duty_active);

    // Minimal configuration: PRESCALE=1, STEPS=2, duty 1 -> toggling output.
    rst2_n = 1'b1; en2 = 1'b1; duty2 = 7'd1;
    tick();
    for (int i = 0; i < 8; i++) begin
      cmp("min_pwm", 32'(pwm2), 32'((i % 2) == 0));
      cmp("min_ps", 32'(ps2), 32'((i % 2) == 0));
      tick();
    end
    $display("minimal config: toggle sequence checked");

    // Random stimulus against the reference model.
    restart(40);
    for (int c = 0; c < 12000; c++) begin
      duty_in = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      rst_n = ($urandom_range(0, 2999) != 0);
      tick();
    end
    $display("random: 12000 cycles applied");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
